// File: rtl/we_evt_pkg.sv
// we_evt_pkg
//   Shared types, readback offsets and helpers for the we_event_monitor block.
//   Readback map (relative to N_CH):
//     SEL_STICKY = N_CH + SEL_STICKY_OFS  -> {snap_cnt, 0, shadow_sticky}
//     SEL_OVF    = N_CH + SEL_OVF_OFS     -> {0, shadow_ovf}
//     SEL_TS_BASE= N_CH + SEL_TS_BASE_OFS -> first timestamp word
//   Optional feature macro: WE_EVT_TIMESTAMP_EN (per-channel timestamp latch).
package we_evt_pkg;

  typedef logic [31:0] rd_word_t;

  localparam int unsigned SEL_STICKY_OFS  = 0;
  localparam int unsigned SEL_OVF_OFS     = 1;
  localparam int unsigned SEL_TS_BASE_OFS = 2;

  // Keep only the low w bits of v; callers pass already zero-extended values.
  function automatic rd_word_t pack(input logic [31:0] v, input int unsigned w);
    rd_word_t m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

endpackage

// File: rtl/we_evt_chan.sv
// we_evt_chan
//   One event channel: rising-edge detect, trigger pulse, event counter with
//   saturate/wrap overflow, sticky "seen" flag and (with WE_EVT_TIMESTAMP_EN)
//   a timestamp latch of the last counted edge.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_evt         level event source
//   i_en          channel enable (0 = no pulse, no count)
//   i_sat_mode    1 = saturate at max, 0 = wrap to 0
//   i_clr         clear counter, overflow, sticky (and timestamp)
//   i_ts / o_ts   free-running timestamp in / last-edge timestamp out (macro only)
//   o_trig        one-cycle pulse per counted edge
//   o_cnt         live event counter
//   o_ovf         counter hit max on an edge since last clear
//   o_sticky      an edge was seen since last clear
module we_evt_chan
  import we_evt_pkg::*;
#(
  parameter int unsigned CNT_W = 32
`ifdef WE_EVT_TIMESTAMP_EN
  , parameter int unsigned TS_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_evt,
  input  logic             i_en,
  input  logic             i_sat_mode,
  input  logic             i_clr,
`ifdef WE_EVT_TIMESTAMP_EN
  input  logic [TS_W-1:0]  i_ts,
  output logic [TS_W-1:0]  o_ts,
`endif
  output logic             o_trig,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf,
  output logic             o_sticky
);

  logic             r_evt_q;
  logic             r_trig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_sticky;
  logic             w_edge;
  logic             w_at_max;

  assign w_edge   = i_evt & ~r_evt_q & i_en;
  assign w_at_max = (r_cnt == '1);

  // Delay flop tracks the input through reset too, so a level already high
  // at release is not taken as an edge, and re-enabling never sees a stale edge.
  always_ff @(posedge clk) begin
    r_evt_q <= i_evt;
  end

  // Clear beats a same-cycle edge for the state, but the pulse still goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig   <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_trig <= w_edge;
      if (i_clr) begin
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
        r_sticky <= 1'b0;
      end else if (w_edge) begin
        r_sticky <= 1'b1;
        if (w_at_max) begin
          r_ovf <= 1'b1;
          r_cnt <= i_sat_mode ? '1 : '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef WE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ts_last <= '0;
    end else if (w_edge) begin
      r_ts_last <= i_ts;
    end
  end

  assign o_ts = r_ts_last;
`endif

  assign o_trig   = r_trig;
  assign o_cnt    = r_cnt;
  assign o_ovf    = r_ovf;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/we_event_monitor.sv
// we_event_monitor
//   N-channel event monitor: per-channel edge detect / trigger / counters
//   (we_evt_chan), plus coherent snapshot shadows, snapshot sequence number
//   and a registered readback mux for WireOut access.
//   Optional feature macro: WE_EVT_TIMESTAMP_EN adds a free-running timestamp
//   counter, per-channel last-edge timestamps and their readback words.
// Ports
//   clk, rst    event clock, synchronous active-high reset
//   evt_in      level event sources            evt_en   per-channel enable
//   sat_mode    1 = saturate, 0 = wrap          clr_trig clear counters/flags
//   snap_trig   copy live state into shadows    rd_sel   readback index
//   rd_data     registered readback word (1-cycle latency, shadows only)
//   trig_out    one-cycle edge pulses           sticky   live seen-since-clear
//   any_ovf     OR of live overflow flags       snap_cnt snapshot sequence number
module we_event_monitor
  import we_evt_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SEL_W = 6,
  parameter int unsigned TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  evt_in,
  input  logic [N_CH-1:0]  evt_en,
  input  logic             sat_mode,
  input  logic             clr_trig,
  input  logic             snap_trig,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [31:0]      rd_data,
  output logic [N_CH-1:0]  trig_out,
  output logic [N_CH-1:0]  sticky,
  output logic             any_ovf,
  output logic [7:0]       snap_cnt
);

  localparam int unsigned SEL_STICKY = N_CH + SEL_STICKY_OFS;
  localparam int unsigned SEL_OVF    = N_CH + SEL_OVF_OFS;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("we_event_monitor: N_CH out of range");
  end
  if (CNT_W < 1 || CNT_W > 32 || TS_W < 1 || TS_W > 32) begin : g_bad_width
    $error("we_event_monitor: CNT_W/TS_W out of range");
  end
  if ((2 ** SEL_W) < (2 * N_CH + 2)) begin : g_bad_sel
    $error("we_event_monitor: SEL_W too narrow");
  end

  logic [CNT_W-1:0] w_cnt    [N_CH];
  logic [N_CH-1:0]  w_trig;
  logic [N_CH-1:0]  w_ovf;
  logic [N_CH-1:0]  w_sticky;

  logic [CNT_W-1:0] r_sh_cnt [N_CH];
  logic [N_CH-1:0]  r_sh_ovf;
  logic [N_CH-1:0]  r_sh_sticky;
  logic [7:0]       r_snap_cnt;
  rd_word_t         r_rd_data;
  rd_word_t         w_rd_word;

`ifdef WE_EVT_TIMESTAMP_EN
  localparam int unsigned SEL_TS_BASE = N_CH + SEL_TS_BASE_OFS;

  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] w_ts_last [N_CH];
  logic [TS_W-1:0] r_sh_ts   [N_CH];

  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + TS_W'(1);
  end
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    we_evt_chan #(
      .CNT_W(CNT_W)
`ifdef WE_EVT_TIMESTAMP_EN
      , .TS_W(TS_W)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_evt      (evt_in[g]),
      .i_en       (evt_en[g]),
      .i_sat_mode (sat_mode),
      .i_clr      (clr_trig),
`ifdef WE_EVT_TIMESTAMP_EN
      .i_ts       (r_ts),
      .o_ts       (w_ts_last[g]),
`endif
      .o_trig     (w_trig[g]),
      .o_cnt      (w_cnt[g]),
      .o_ovf      (w_ovf[g]),
      .o_sticky   (w_sticky[g])
    );
  end

  // Channel outputs are registers, so sampling them here captures the values
  // from before any same-cycle edge or clear: snapshot-before-clear falls out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_sh_cnt[i] <= '0;
`ifdef WE_EVT_TIMESTAMP_EN
        r_sh_ts[i]  <= '0;
`endif
      end
      r_sh_ovf    <= '0;
      r_sh_sticky <= '0;
      r_snap_cnt  <= '0;
    end else if (snap_trig) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_sh_cnt[i] <= w_cnt[i];
`ifdef WE_EVT_TIMESTAMP_EN
        r_sh_ts[i]  <= w_ts_last[i];
`endif
      end
      r_sh_ovf    <= w_ovf;
      r_sh_sticky <= w_sticky;
      r_snap_cnt  <= r_snap_cnt + 8'd1;
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_sel == SEL_W'(i)) w_rd_word = pack(32'(r_sh_cnt[i]), CNT_W);
`ifdef WE_EVT_TIMESTAMP_EN
      if (rd_sel == SEL_W'(SEL_TS_BASE + i)) w_rd_word = pack(32'(r_sh_ts[i]), TS_W);
`endif
    end
    if (rd_sel == SEL_W'(SEL_STICKY)) w_rd_word = {r_snap_cnt, 24'(r_sh_sticky)};
    if (rd_sel == SEL_W'(SEL_OVF))    w_rd_word = pack(32'(r_sh_ovf), N_CH);
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_word;
  end

  assign rd_data  = r_rd_data;
  assign trig_out = w_trig;
  assign sticky   = w_sticky;
  assign any_ovf  = |w_ovf;
  assign snap_cnt = r_snap_cnt;

endmodule

// File: tb/tb_we_event_monitor.sv
module tb_we_event_monitor;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  evt_in;
  logic [N_CH-1:0]  evt_en;
  logic             sat_mode;
  logic             clr_trig;
  logic             snap_trig;
  logic [SEL_W-1:0] rd_sel;
  logic [31:0]      rd_data;
  logic [N_CH-1:0]  trig_out;
  logic [N_CH-1:0]  sticky;
  logic             any_ovf;
  logic [7:0]       snap_cnt;

  we_event_monitor #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .SEL_W(SEL_W),
    .TS_W (TS_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt_in   (evt_in),
    .evt_en   (evt_en),
    .sat_mode (sat_mode),
    .clr_trig (clr_trig),
    .snap_trig(snap_trig),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .trig_out (trig_out),
    .sticky   (sticky),
    .any_ovf  (any_ovf),
    .snap_cnt (snap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit              m_valid = 0;
  bit [N_CH-1:0]   m_prev;
  int unsigned     m_cnt  [N_CH];
  int unsigned     m_tsl  [N_CH];
  bit [N_CH-1:0]   m_ovf, m_sticky;
  int unsigned     m_ts;
  int unsigned     s_cnt  [N_CH];
  int unsigned     s_tsl  [N_CH];
  bit [N_CH-1:0]   s_ovf, s_sticky;
  int unsigned     m_snap;
  logic [31:0]     e_rd;
  logic [N_CH-1:0] e_trig;

  function automatic logic [31:0] model_read(input int unsigned sel);
    if (sel < N_CH) return s_cnt[sel];
    if (sel == N_CH) return (m_snap << 24) | 32'(s_sticky);
    if (sel == N_CH + 1) return 32'(s_ovf);
`ifdef WE_EVT_TIMESTAMP_EN
    if (sel >= N_CH + 2 && sel < 2 * N_CH + 2) return s_tsl[sel - N_CH - 2];
`endif
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit [N_CH-1:0] edges;
    if (rst) begin
      m_prev = evt_in;
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_tsl[i] = 0; s_cnt[i] = 0; s_tsl[i] = 0;
      end
      m_ovf = '0; m_sticky = '0; s_ovf = '0; s_sticky = '0;
      m_ts = 0; m_snap = 0; e_rd = 0; e_trig = '0;
      m_valid = 1;
    end else begin
      edges  = evt_in & ~m_prev & evt_en;
      m_prev = evt_in;
      e_rd   = model_read(int'(rd_sel));
      if (snap_trig) begin
        s_cnt = m_cnt; s_tsl = m_tsl; s_ovf = m_ovf; s_sticky = m_sticky;
        m_snap = (m_snap + 1) % 256;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (edges[i]) begin
          m_sticky[i] = 1'b1;
          m_tsl[i] = m_ts;
          if (m_cnt[i] == CMAX) begin
            m_ovf[i] = 1'b1;
            m_cnt[i] = sat_mode ? CMAX : 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (clr_trig) begin
        for (int i = 0; i < N_CH; i++) begin m_cnt[i] = 0; m_tsl[i] = 0; end
        m_ovf = '0; m_sticky = '0;
      end
      m_ts   = (m_ts + 1) % (1 << TS_W);
      e_trig = edges;
    end
  end

  // Single compare process against the model, every cycle after reset seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("trig_out", 32'(trig_out), 32'(e_trig));
      check("sticky", 32'(sticky), 32'(m_sticky));
      check("any_ovf", 32'(any_ovf), 32'(|m_ovf));
      check("snap_cnt", 32'(snap_cnt), m_snap);
      check("rd_data", rd_data, e_rd);
    end
  end

  // Independent count of trigger pulses seen on the DUT outputs.
  int tcnt [N_CH];
  initial for (int k = 0; k < N_CH; k++) tcnt[k] = 0;
  always @(negedge clk) begin
    for (int k = 0; k < N_CH; k++) if (trig_out[k] === 1'b1) tcnt[k]++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_snap();
    snap_trig = 1'b1; cyc(1); snap_trig = 1'b0;
  endtask

  task automatic do_clr();
    clr_trig = 1'b1; cyc(1); clr_trig = 1'b0;
  endtask

  task automatic rd(input int unsigned sel, output logic [31:0] v);
    rd_sel = SEL_W'(sel); cyc(1); v = rd_data;
  endtask

  task automatic pulse_ch(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      evt_in[ch] = 1'b1; cyc(1);
      evt_in[ch] = 1'b0; cyc(1);
    end
  endtask

  logic [31:0] v;
  int base;
  bit found;

  initial begin
    rst = 1'b1; evt_in = 8'h01; evt_en = '1; sat_mode = 1'b1;
    clr_trig = 1'b0; snap_trig = 1'b0; rd_sel = '0;
    cyc(3);
    rst = 1'b0;
    check("reset_rd", rd_data, 32'h0);
    check("reset_snap", 32'(snap_cnt), 32'h0);
    check("reset_trig", 32'(trig_out), 32'h0);
    check("reset_ovf", 32'(any_ovf), 32'h0);

    // Level high through reset release is not an edge.
    cyc(10);
    check("t1_trig0", tcnt[0], 0);
    do_snap(); rd(0, v);
    check("t1_cnt0", v, 32'd0);
    evt_in[0] = 1'b0; cyc(1);

    // Five edges on ch2.
    base = tcnt[2];
    pulse_ch(2, 5);
    do_snap(); rd(2, v);
    check("t2_cnt2", v, 32'd5);
    check("t2_trig2", tcnt[2] - base, 5);

    // Saturate, then wrap, with 17 edges on a 4-bit counter.
    do_clr(); sat_mode = 1'b1;
    pulse_ch(1, 17);
    do_snap(); rd(1, v);
    check("t3_sat_cnt1", v, 32'd15);
    rd(N_CH + 1, v);
    check("t3_sat_ovf", v, 32'h2);
    do_clr(); sat_mode = 1'b0;
    pulse_ch(1, 17);
    do_snap(); rd(1, v);
    check("t3_wrap_cnt1", v, 32'd1);
    rd(N_CH + 1, v);
    check("t3_wrap_ovf", v, 32'h2);
    sat_mode = 1'b1;

    // Edge, clear and snapshot in the same cycle.
    do_clr();
    pulse_ch(3, 7);
    evt_in[3] = 1'b1; clr_trig = 1'b1; snap_trig = 1'b1;
    cyc(1);
    evt_in[3] = 1'b0; clr_trig = 1'b0; snap_trig = 1'b0;
    check("t4_trig3", 32'(trig_out[3]), 32'h1);
    check("t4_sticky3", 32'(sticky[3]), 32'h0);
    rd(3, v);
    check("t4_shadow3", v, 32'd7);
    do_snap(); rd(3, v);
    check("t4_live3", v, 32'd0);

    // Enable gating on ch4.
    base = tcnt[4];
    evt_en[4] = 1'b0;
    pulse_ch(4, 3);
    evt_en[4] = 1'b1;
    pulse_ch(4, 2);
    do_snap(); rd(4, v);
    check("t5_cnt4", v, 32'd2);
    check("t5_trig4", tcnt[4] - base, 2);

    // Timestamp of an edge on ch0 at timestamp 100.
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_ts == 100) found = 1;
      else cyc(1);
    end
    check("t6_ts_reached", 32'(found), 32'h1);
    evt_in[0] = 1'b1; cyc(1); evt_in[0] = 1'b0; cyc(1);
    do_snap(); rd(N_CH + 2, v);
`ifdef WE_EVT_TIMESTAMP_EN
    check("t6_ts0", v, 32'd100);
`else
    check("t6_ts0", v, 32'd0);
`endif

    // Randomised run against the model.
    for (int k = 0; k < 3000; k++) begin
      evt_in    = N_CH'($urandom);
      evt_en    = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '1;
      if ($urandom_range(0, 19) == 0) sat_mode = ~sat_mode;
      clr_trig  = ($urandom_range(0, 40) == 0);
      snap_trig = ($urandom_range(0, 6) == 0);
      rd_sel    = SEL_W'($urandom_range(0, 63));
      rst       = ($urandom_range(0, 700) == 0);
      cyc(1);
    end
    rst = 1'b0; clr_trig = 1'b0; snap_trig = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
